// File: rtl/err_stat_multi_if.sv
// Bundle of the error-statistics block's strobes, control inputs and readout outputs.
// The master modport drives the inputs; the slave modport is the statistics block itself.
interface err_stat_multi_if #(
    parameter int N_CH  = 16,
    parameter int CNT_W = 16
);
    logic [N_CH-1:0]       send_err;
    logic [N_CH-1:0]       err;
    logic                  clr;
    logic                  snap;
    logic                  rd_en;
    logic [5:0]            rd_addr;
    logic [N_CH*CNT_W-1:0] cnt_flat;
    logic [N_CH-1:0]       armed;
    logic [N_CH-1:0]       sat;
    logic                  any_err;
    logic [CNT_W-1:0]      rd_data;
    logic                  rd_valid;
    logic                  rd_oob;

    modport master (
        output send_err, err, clr, snap, rd_en, rd_addr,
        input  cnt_flat, armed, sat, any_err, rd_data, rd_valid, rd_oob
    );

    modport slave (
        input  send_err, err, clr, snap, rd_en, rd_addr,
        output cnt_flat, armed, sat, any_err, rd_data, rd_valid, rd_oob
    );
endinterface

// File: rtl/err_stat_multi.sv
// Per-channel saturating error counters, each armed by its first send_err rising edge,
// with synchronous clear, a snapshot bank and an addressed snapshot readout.
module err_stat_multi #(
    parameter int N_CH       = 16,
    parameter int CNT_W      = 16,
    parameter int LEVEL_MODE = 0
) (
    input logic             clk,
    input logic             reset,
    err_stat_multi_if.slave bus
);
    // All ones marks a never-armed channel; armed counters stop one below it.
    localparam logic [CNT_W-1:0] MAX_V  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SAT_V  = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] SAT_M1 = SAT_V - 1'b1;

    logic [CNT_W-1:0]      cnt_q  [N_CH];
    logic [CNT_W-1:0]      snap_q [N_CH];
    logic [N_CH-1:0]       armed_q;
    logic [N_CH-1:0]       sat_q;
    logic [N_CH-1:0]       pre_q;
    logic [N_CH-1:0]       rise;
    logic [N_CH-1:0]       inc_ok;
    logic [N_CH-1:0]       nz;
    logic [N_CH*CNT_W-1:0] cnt_cat;
    logic [CNT_W-1:0]      rd_mux;
    logic                  rd_in_range;

    always_comb begin
        rise    = bus.send_err & ~pre_q;
        inc_ok  = '0;
        nz      = '0;
        cnt_cat = '0;
        for (int i = 0; i < N_CH; i++) begin
            inc_ok[i] = armed_q[i] && bus.err[i] &&
                        ((LEVEL_MODE != 0) ? bus.send_err[i] : rise[i]) &&
                        (cnt_q[i] < SAT_V);
            nz[i] = armed_q[i] && (cnt_q[i] != '0);
            cnt_cat[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    // Addresses with no matching channel fall through to the never-armed marker.
    always_comb begin
        rd_mux      = MAX_V;
        rd_in_range = ({1'b0, bus.rd_addr} < 7'(N_CH));
        for (int i = 0; i < N_CH; i++) begin
            if (bus.rd_addr == 6'(i)) rd_mux = snap_q[i];
        end
    end

    // Arming only applies to unarmed channels and clear only to armed ones, so an
    // arm and a clear in the same cycle leave the channel armed at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= MAX_V;
                snap_q[i] <= MAX_V;
            end
            armed_q <= '0;
            sat_q   <= '0;
            pre_q   <= '0;
        end else begin
            pre_q <= bus.send_err;
            for (int i = 0; i < N_CH; i++) begin
                if (bus.snap) snap_q[i] <= cnt_q[i];
                if (!armed_q[i] && rise[i]) begin
                    armed_q[i] <= 1'b1;
                    cnt_q[i]   <= '0;
                    sat_q[i]   <= 1'b0;
                end else if (bus.clr && armed_q[i]) begin
                    cnt_q[i] <= '0;
                    sat_q[i] <= 1'b0;
                end else if (inc_ok[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                    sat_q[i] <= (cnt_q[i] == SAT_M1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cnt_flat <= '1;
            bus.armed    <= '0;
            bus.sat      <= '0;
            bus.any_err  <= 1'b0;
        end else begin
            bus.cnt_flat <= cnt_cat;
            bus.armed    <= armed_q;
            bus.sat      <= sat_q;
            bus.any_err  <= |nz;
        end
    end

    // rd_en/rd_valid: a request is accepted every cycle rd_en is high (there is no
    // ready); rd_valid pulses exactly once, the cycle after, carrying rd_data/rd_oob.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_oob   <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rd_data <= rd_mux;
                bus.rd_oob  <= ~rd_in_range;
            end
        end
    end
endmodule

// File: tb/tb_err_stat_multi.sv
// Bench for err_stat_multi: three configurations (16x16 edge mode, 4x4 edge mode,
// 4x8 level mode) driven with directed and random stimulus against a channel model.
module tb_err_stat_multi;
    localparam int NCH [3] = '{16, 4, 4};
    localparam int CW  [3] = '{16, 4, 8};
    localparam int LM  [3] = '{0, 0, 1};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [15:0] se_v [3];
    logic [15:0] er_v [3];
    logic        clr_v [3];
    logic        snap_v [3];
    logic        rden_v [3];
    logic [5:0]  addr_v [3];

    logic [255:0] cf_v [3];
    logic [15:0]  arm_v [3];
    logic [15:0]  sat_v [3];
    logic         any_v [3];
    logic [31:0]  rdd_v [3];
    logic         rdv_v [3];
    logic         oob_v [3];

    err_stat_multi_if #(.N_CH(16), .CNT_W(16)) if0 ();
    err_stat_multi_if #(.N_CH(4),  .CNT_W(4))  if1 ();
    err_stat_multi_if #(.N_CH(4),  .CNT_W(8))  if2 ();

    err_stat_multi #(.N_CH(16), .CNT_W(16), .LEVEL_MODE(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    err_stat_multi #(.N_CH(4),  .CNT_W(4),  .LEVEL_MODE(0)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    err_stat_multi #(.N_CH(4),  .CNT_W(8),  .LEVEL_MODE(1)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    assign if0.send_err = se_v[0];
    assign if0.err      = er_v[0];
    assign if0.clr      = clr_v[0];
    assign if0.snap     = snap_v[0];
    assign if0.rd_en    = rden_v[0];
    assign if0.rd_addr  = addr_v[0];
    assign if1.send_err = se_v[1][3:0];
    assign if1.err      = er_v[1][3:0];
    assign if1.clr      = clr_v[1];
    assign if1.snap     = snap_v[1];
    assign if1.rd_en    = rden_v[1];
    assign if1.rd_addr  = addr_v[1];
    assign if2.send_err = se_v[2][3:0];
    assign if2.err      = er_v[2][3:0];
    assign if2.clr      = clr_v[2];
    assign if2.snap     = snap_v[2];
    assign if2.rd_en    = rden_v[2];
    assign if2.rd_addr  = addr_v[2];

    assign cf_v[0]  = if0.cnt_flat;
    assign cf_v[1]  = 256'(if1.cnt_flat);
    assign cf_v[2]  = 256'(if2.cnt_flat);
    assign arm_v[0] = if0.armed;
    assign arm_v[1] = 16'(if1.armed);
    assign arm_v[2] = 16'(if2.armed);
    assign sat_v[0] = if0.sat;
    assign sat_v[1] = 16'(if1.sat);
    assign sat_v[2] = 16'(if2.sat);
    assign any_v[0] = if0.any_err;
    assign any_v[1] = if1.any_err;
    assign any_v[2] = if2.any_err;
    assign rdd_v[0] = 32'(if0.rd_data);
    assign rdd_v[1] = 32'(if1.rd_data);
    assign rdd_v[2] = 32'(if2.rd_data);
    assign rdv_v[0] = if0.rd_valid;
    assign rdv_v[1] = if1.rd_valid;
    assign rdv_v[2] = if2.rd_valid;
    assign oob_v[0] = if0.rd_oob;
    assign oob_v[1] = if1.rd_oob;
    assign oob_v[2] = if2.rd_oob;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: live counters, arming, previous strobe, snapshot bank, and the
    // copy of the live state that the registered outputs should be showing.
    int          m_cnt  [3][16];
    int          m_snap [3][16];
    int          d_cnt  [3][16];
    bit          m_arm  [3][16];
    bit          d_arm  [3][16];
    bit          m_pre  [3][16];
    bit          exp_rv [3];
    logic [39:0] exp_q[$];

    function automatic int maxv(input int i);
        return (1 << CW[i]) - 1;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] fld(input int i, input int c);
        logic [255:0] sh;
        sh = cf_v[i] >> (c * CW[i]);
        return 64'(sh[31:0]) & 64'(maxv(i));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 16; c++) begin
                m_cnt[i][c]  = maxv(i);
                m_snap[i][c] = maxv(i);
                d_cnt[i][c]  = maxv(i);
                m_arm[i][c]  = 1'b0;
                d_arm[i][c]  = 1'b0;
                m_pre[i][c]  = 1'b0;
            end
            exp_rv[i] = 1'b0;
        end
        exp_q.delete();
    endfunction

    function automatic void model_step();
        int  mx;
        bit  se, e, rise, oob;
        int  data;
        for (int i = 0; i < 3; i++) begin
            mx = maxv(i);
            for (int c = 0; c < NCH[i]; c++) begin
                d_cnt[i][c] = m_cnt[i][c];
                d_arm[i][c] = m_arm[i][c];
            end
            exp_rv[i] = rden_v[i];
            if (rden_v[i]) begin
                oob  = (int'(addr_v[i]) >= NCH[i]);
                data = oob ? mx : m_snap[i][addr_v[i]];
                exp_q.push_back({6'(i), 1'b0, oob, 32'(data)});
            end
            if (snap_v[i]) begin
                for (int c = 0; c < NCH[i]; c++) m_snap[i][c] = m_cnt[i][c];
            end
            for (int c = 0; c < NCH[i]; c++) begin
                se   = se_v[i][c];
                e    = er_v[i][c];
                rise = se && !m_pre[i][c];
                if (!m_arm[i][c] && rise) begin
                    m_arm[i][c] = 1'b1;
                    m_cnt[i][c] = 0;
                end else if (clr_v[i] && m_arm[i][c]) begin
                    m_cnt[i][c] = 0;
                end else if (m_arm[i][c] && e && (LM[i] != 0 ? se : rise) && m_cnt[i][c] < mx - 1) begin
                    m_cnt[i][c] = m_cnt[i][c] + 1;
                end
                m_pre[i][c] = se;
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    function automatic void check_all();
        bit          any_exp;
        logic [39:0] e;
        for (int i = 0; i < 3; i++) begin
            any_exp = 1'b0;
            for (int c = 0; c < NCH[i]; c++) begin
                chk($sformatf("cnt i%0d c%0d", i, c), fld(i, c), 64'(d_cnt[i][c]));
                chk($sformatf("armed i%0d c%0d", i, c), 64'(arm_v[i][c]), 64'(d_arm[i][c]));
                chk($sformatf("sat i%0d c%0d", i, c), 64'(sat_v[i][c]),
                    64'(d_arm[i][c] && d_cnt[i][c] == maxv(i) - 1));
                if (d_arm[i][c] && d_cnt[i][c] != 0) any_exp = 1'b1;
            end
            chk($sformatf("any_err i%0d", i), 64'(any_v[i]), 64'(any_exp));
            chk($sformatf("rd_valid i%0d", i), 64'(rdv_v[i]), 64'(exp_rv[i]));
            if (exp_rv[i] && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("rd_data i%0d", i), 64'(rdd_v[i]), 64'(e[31:0]));
                chk($sformatf("rd_oob i%0d", i), 64'(oob_v[i]), 64'(e[32]));
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic zero_inputs();
        for (int i = 0; i < 3; i++) begin
            se_v[i] = '0; er_v[i] = '0; clr_v[i] = 1'b0; snap_v[i] = 1'b0;
            rden_v[i] = 1'b0; addr_v[i] = '0;
        end
    endtask

    task automatic pulse(input int i, input int c, input int n);
        for (int k = 0; k < n; k++) begin
            se_v[i][c] = 1'b1; er_v[i][c] = 1'b1;
            step();
            se_v[i][c] = 1'b0;
            step();
        end
        er_v[i][c] = 1'b0;
    endtask

    task automatic check_reset_literals(input string tag);
        chk({tag, " cnt_flat0"}, 64'(if0.cnt_flat[63:0]), 64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, " cnt_flat0 top"}, 64'(if0.cnt_flat[255:192]), 64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, " armed0"}, 64'(if0.armed), 64'h0);
        chk({tag, " sat0"}, 64'(if0.sat), 64'h0);
        chk({tag, " any_err0"}, 64'(if0.any_err), 64'h0);
        chk({tag, " rd_data0"}, 64'(if0.rd_data), 64'h0);
        chk({tag, " rd_valid0"}, 64'(if0.rd_valid), 64'h0);
        chk({tag, " rd_oob0"}, 64'(if0.rd_oob), 64'h0);
        chk({tag, " cnt_flat1"}, 64'(if1.cnt_flat), 64'hFFFF);
    endtask

    initial begin
        reset = 1'b1;
        zero_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all();
        check_reset_literals("reset");

        // Channel 3: first rise arms, five further rises count.
        pulse(0, 3, 6);
        step();
        chk("tp1 cnt3", fld(0, 3), 64'd5);
        chk("tp1 armed3", 64'(if0.armed[3]), 64'd1);
        chk("tp1 cnt0", fld(0, 0), 64'hFFFF);
        chk("tp1 cnt15", fld(0, 15), 64'hFFFF);
        chk("tp1 any_err", 64'(if0.any_err), 64'd1);

        // 4-bit counter: saturates at 14, then clear.
        pulse(1, 0, 21);
        step();
        chk("tp2 cnt0 sat", fld(1, 0), 64'hE);
        chk("tp2 sat0", 64'(if1.sat[0]), 64'd1);
        clr_v[1] = 1'b1;
        step();
        clr_v[1] = 1'b0;
        step();
        chk("tp2 cnt0 clr", fld(1, 0), 64'd0);
        chk("tp2 sat0 clr", 64'(if1.sat[0]), 64'd0);
        chk("tp2 armed0 clr", 64'(if1.armed[0]), 64'd1);

        // Level mode: eight high cycles arm on the first and count seven.
        se_v[2][1] = 1'b1; er_v[2][1] = 1'b1;
        repeat (8) step();
        se_v[2][1] = 1'b0; er_v[2][1] = 1'b0;
        step();
        chk("tp3 cnt1", fld(2, 1), 64'd7);

        // Snap with clear captures the pre-clear value.
        pulse(0, 2, 10);
        snap_v[0] = 1'b1; clr_v[0] = 1'b1;
        step();
        snap_v[0] = 1'b0; clr_v[0] = 1'b0;
        rden_v[0] = 1'b1; addr_v[0] = 6'd2;
        step();
        chk("tp4 rd_valid", 64'(if0.rd_valid), 64'd1);
        chk("tp4 rd_data", 64'(if0.rd_data), 64'd9);
        chk("tp4 cnt2", fld(0, 2), 64'd0);

        // Out-of-range address, then a never-armed channel.
        addr_v[0] = 6'd16;
        step();
        chk("tp5 oob data", 64'(if0.rd_data), 64'hFFFF);
        chk("tp5 oob flag", 64'(if0.rd_oob), 64'd1);
        addr_v[0] = 6'd5;
        step();
        chk("tp5 ch5 data", 64'(if0.rd_data), 64'hFFFF);
        chk("tp5 ch5 oob", 64'(if0.rd_oob), 64'd0);
        rden_v[0] = 1'b0;
        step();

        // Random traffic on all three configurations.
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < 3; i++) begin
                se_v[i]   = 16'($urandom) & ((i == 0) ? 16'hFFFF : 16'h000F);
                er_v[i]   = 16'($urandom) & ((i == 0) ? 16'hFFFF : 16'h000F);
                clr_v[i]  = ($urandom_range(0, 24) == 0);
                snap_v[i] = ($urandom_range(0, 7) == 0);
                rden_v[i] = ($urandom_range(0, 1) == 1);
                addr_v[i] = 6'($urandom_range(0, 20));
            end
            step();
        end
        zero_inputs();
        step();

        // Asynchronous reset while channel 7 counts and a read is pending.
        se_v[0][7] = 1'b1; er_v[0][7] = 1'b1;
        step();
        se_v[0][7] = 1'b0;
        step();
        se_v[0][7] = 1'b1;
        step();
        se_v[0][7] = 1'b0;
        rden_v[0] = 1'b1; addr_v[0] = 6'd7;
        #2 reset = 1'b1;
        #1;
        check_reset_literals("async");
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        zero_inputs();
        reset = 1'b0;
        step();
        chk("async no rd_valid", 64'(if0.rd_valid), 64'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/err_stat_multi.md
# err_stat_multi

Parametrised per-channel error-statistics block, successor to the fixed 16×16-bit error counter bank. Each channel has a saturating error counter that is armed by its first `send_err` rising edge and counts `err` at later sample events. The block adds a selectable counting mode, a synchronous clear, a snapshot bank and an addressed readout port. It sits between the link/decoder error flags and the slow-control register file.

## Interface
- `N_CH`, 16, number of channels (1..64)
- `CNT_W`, 16, counter width in bits (4..32)
- `LEVEL_MODE`, 0, 0 = count at `send_err` rising edge only (legacy); 1 = count every cycle `send_err` is high after arming
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `send_err`  in  N_CH  per-channel sample/window strobe
- `err`  in  N_CH  per-channel error flag, sampled with `send_err`
- `clr`  in  1  synchronous clear of all armed counters to 0
- `snap`  in  1  copy all live counters into snapshot bank
- `rd_en`  in  1  readout request
- `rd_addr`  in  6  snapshot channel index
- `cnt_flat`  out  N_CH*CNT_W  registered live counters, channel i at bits [i*CNT_W +: CNT_W]
- `armed`  out  N_CH  registered per-channel armed flags
- `sat`  out  N_CH  registered per-channel saturation flags
- `any_err`  out  1  registered OR over channels of (armed and counter ≠ 0)
- `rd_data`  out  CNT_W  snapshot value for `rd_addr`
- `rd_valid`  out  1  `rd_data` valid strobe
- `rd_oob`  out  1  `rd_addr` ≥ N_CH on the accepted request

## Operation
- MAX = 2^CNT_W − 1 is the "never armed" marker. SAT = MAX − 1 is the saturation ceiling.
- Per channel, with `pre` = `send_err` delayed one cycle and `rise` = `send_err & ~pre`:
  - Unarmed and `rise`: set armed = 1 and counter = 0. `err` is ignored on the arming event.
  - Armed, `LEVEL_MODE=0`: on `rise` with `err`=1 and counter < SAT, increment by 1.
  - Armed, `LEVEL_MODE=1`: on any cycle with `send_err`=1 and `err`=1 and counter < SAT, increment by 1. The arming cycle does not count.
  - At SAT: the counter holds and `sat`=1 until `clr` or `reset`.
- `clr`: every armed counter goes to 0 and its `sat` to 0. Armed flags and unarmed counters (MAX) are unchanged.
- Priority per channel, per cycle: `reset` > `clr` > arm > increment.
  - An arm and a `clr` in the same cycle: the channel arms and its counter = 0.
- `snap`: the snapshot bank captures the live counter values as they stood before this cycle's update. `snap` and `clr` together therefore captures the pre-clear values.
- Readout: `rd_en` is accepted every cycle, with no backpressure.
  - For `rd_addr` < N_CH: `rd_data` = snapshot[`rd_addr`] and `rd_oob` = 0.
  - Otherwise: `rd_data` = MAX and `rd_oob` = 1.
- `snap` and `rd_en` in the same cycle: the read returns the old snapshot value.

## Timing
- Reset (asynchronous assert; release synchronous to `clk` externally):
  - counters = MAX, armed = 0, sat = 0, `pre` = 0
  - snapshot bank = MAX
  - `cnt_flat` = all ones, `armed` = 0, `sat` = 0, `any_err` = 0
  - `rd_data` = 0, `rd_valid` = 0, `rd_oob` = 0
- Because `pre` resets to 0, a `send_err` already high in the first post-reset cycle is a rising edge and arms the channel.
- Inputs sampled at edge k update the internal counter at edge k. `cnt_flat`, `armed`, `sat` and `any_err` reflect that update at edge k+1 (latency 2 edges from input to output).
- `snap` at edge k: the snapshot holds the values at edge k. A read issued at edge k+1 or later returns them.
- `rd_en` at edge k: `rd_data`, `rd_valid`=1 and `rd_oob` appear at edge k+1. `rd_valid` is a 1-cycle pulse per request, and back-to-back requests give back-to-back pulses.
- Reset asserted mid-count or mid-read: all state goes to reset values immediately, and a pending `rd_valid` is dropped.
- Widths: the increment is computed at CNT_W bits. The SAT check prevents wrap, so the counter never reaches MAX once armed.

## Test plan
- Reset, then the first `send_err[3]` rise with `err[3]`=1, then 5 more rises with `err[3]`=1 (`LEVEL_MODE=0`) → `armed[3]`=1 and counter 3 = 5. All other channels read all ones and `any_err`=1.
- `CNT_W=4`: arm channel 0, then 20 counting rises → counter goes 0..14, holds at 14 (0xE), `sat[0]`=1. Then `clr` → counter 0 and `sat[0]`=0 with `armed[0]` still 1.
- `LEVEL_MODE=1`: `send_err[1]` held high for 8 cycles with `err[1]`=1 from the first cycle → arms on cycle 1, counter = 7.
- `snap` and `clr` in the same cycle with counter 2 = 9; then `rd_en`, `rd_addr`=2 → `rd_data`=9 and `rd_valid` one cycle later, while `cnt_flat` channel 2 = 0.
- `rd_addr`=N_CH (16) → `rd_data`=0xFFFF and `rd_oob`=1. Then `rd_addr`=5 on the next cycle for a never-armed channel → `rd_data`=0xFFFF and `rd_oob`=0.
- `reset` pulsed asynchronously between clock edges while channel 7 is counting and a read is pending → all outputs take their reset values before the next edge, and no `rd_valid` is produced.
